// File: rtl/code_detector_pkg.sv
// Shared state type, width helper and one-hot key helpers for the parametrised code lock.
package code_detector_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_ENTER = 3'd1,
    ST_OPEN  = 3'd2,
    ST_PROG  = 3'd3,
    ST_LOCK  = 3'd4
  } state_e;

  // Key vectors are zero-extended to this width before decoding.
  localparam int MAX_KEYS = 32;
  localparam int MAX_KW   = 5;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_onehot(input logic [MAX_KEYS-1:0] v);
    return (v != {MAX_KEYS{1'b0}}) && ((v & (v - 32'd1)) == {MAX_KEYS{1'b0}});
  endfunction

  function automatic logic [MAX_KW-1:0] onehot_to_index(input logic [MAX_KEYS-1:0] v);
    logic [MAX_KW-1:0] idx;
    idx = {MAX_KW{1'b0}};
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (v[i]) begin
        idx = i[MAX_KW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/code_detector_param_key_decoder.sv
// Classifies the raw key vector as idle, a valid single press, or invalid, and yields the key index.
module key_decoder
  import code_detector_pkg::*;
#(
  parameter  int NUM_KEYS = 3,
  localparam int KW       = min1_clog2(NUM_KEYS)
) (
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic                idle_o,
  output logic                valid_o,
  output logic [KW-1:0]       idx_o
);

  logic [MAX_KEYS-1:0] keys_ext_s;

  assign keys_ext_s = MAX_KEYS'(keys_i);
  assign idle_o     = (keys_i == {NUM_KEYS{1'b0}});
  assign valid_o    = is_onehot(keys_ext_s);
  assign idx_o      = KW'(onehot_to_index(keys_ext_s));

endmodule

// File: rtl/code_detector_param.sv
// Parametrised keypad lock: code entry with idle timeout, failure lockout,
// timed open window and code reprogramming while open.
module code_detector_param
  import code_detector_pkg::*;
#(
  parameter int NUM_KEYS = 3,
  parameter int CODE_LEN = 4,
  parameter logic [CODE_LEN*min1_clog2(NUM_KEYS)-1:0] DEFAULT_CODE = 8'h92,
  parameter int TIMEOUT = 16,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 32,
  parameter int OPEN_CYCLES = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          S,
  input  logic [NUM_KEYS-1:0]           Keys,
  input  logic                          Prog,
  output logic                          U,
  output logic                          Err,
  output logic                          Locked,
  output logic                          ProgMode,
  output logic [$clog2(MAX_FAIL+1)-1:0] FailCnt
);

  localparam int KW = min1_clog2(NUM_KEYS);
  localparam int SW = min1_clog2(CODE_LEN);
  localparam int IW = min1_clog2(TIMEOUT);
  localparam int TW = min1_clog2((LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int CW = CODE_LEN * KW;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [CW-1:0]   code_q, code_d, shadow_q, shadow_d;
  logic [FW-1:0]   fail_q, fail_d, fail_inc_s;
  logic            err_d;
  logic            u_q, err_q, locked_q, prog_q;
  logic            key_idle_s, key_valid_s;
  logic [KW-1:0]   key_idx_s, code_key_s;
  logic            step_last_s, idle_last_s;

  key_decoder #(.NUM_KEYS(NUM_KEYS)) u_dec (
    .keys_i  (Keys),
    .idle_o  (key_idle_s),
    .valid_o (key_valid_s),
    .idx_o   (key_idx_s)
  );

  assign code_key_s  = code_q[KW*int'(step_q) +: KW];
  assign step_last_s = (step_q == SW'(CODE_LEN - 1));
  assign idle_last_s = (idle_q == IW'(TIMEOUT - 1));
  assign fail_inc_s  = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);

  // Next-state logic for the lock sequencer.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    idle_d   = idle_q;
    tmr_d    = tmr_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    fail_d   = fail_q;
    err_d    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (S) begin
          state_d = ST_ENTER;
          step_d  = {SW{1'b0}};
          idle_d  = {IW{1'b0}};
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ENTER: begin
        if (key_idle_s) begin
          if (idle_last_s) state_d = ST_WAIT;
          else             idle_d  = idle_q + IW'(1);
        end else if (key_valid_s && (key_idx_s == code_key_s)) begin
          idle_d = {IW{1'b0}};
          if (step_last_s) begin
            state_d = ST_OPEN;
            tmr_d   = {TW{1'b0}};
            fail_d  = {FW{1'b0}};
          end else begin
            step_d = step_q + SW'(1);
          end
        end else begin
          err_d  = 1'b1;
          fail_d = fail_inc_s;
          if (fail_inc_s == FW'(MAX_FAIL)) begin
            state_d = ST_LOCK;
            tmr_d   = {TW{1'b0}};
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_OPEN: begin
        if (Prog) begin
          state_d = ST_PROG;
          step_d  = {SW{1'b0}};
          idle_d  = {IW{1'b0}};
        end else if (S || (tmr_q == TW'(OPEN_CYCLES - 1))) begin
          state_d = ST_WAIT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_PROG: begin
        if (key_idle_s) begin
          if (idle_last_s) state_d = ST_WAIT;
          else             idle_d  = idle_q + IW'(1);
        end else if (key_valid_s) begin
          shadow_d[KW*int'(step_q) +: KW] = key_idx_s;
          idle_d = {IW{1'b0}};
          // The last press commits the complete shadow, including itself.
          if (step_last_s) begin
            code_d  = shadow_d;
            state_d = ST_WAIT;
          end else begin
            step_d = step_q + SW'(1);
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_LOCK: begin
        if (tmr_q == TW'(LOCK_CYCLES - 1)) begin
          state_d = ST_WAIT;
          fail_d  = {FW{1'b0}};
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // State, counters, code store and Moore outputs decoded from the next state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_WAIT;
      step_q   <= {SW{1'b0}};
      idle_q   <= {IW{1'b0}};
      tmr_q    <= {TW{1'b0}};
      code_q   <= DEFAULT_CODE;
      shadow_q <= {CW{1'b0}};
      fail_q   <= {FW{1'b0}};
      u_q      <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      prog_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      idle_q   <= idle_d;
      tmr_q    <= tmr_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
      fail_q   <= fail_d;
      u_q      <= (state_d == ST_OPEN);
      err_q    <= err_d;
      locked_q <= (state_d == ST_LOCK);
      prog_q   <= (state_d == ST_PROG);
    end
  end

  assign U        = u_q;
  assign Err      = err_q;
  assign Locked   = locked_q;
  assign ProgMode = prog_q;
  assign FailCnt  = fail_q;

endmodule

// File: tb/tb_code_detector_param.sv
// Directed and randomised checks of code_detector_param against a behavioural lock model.
module tb_code_detector_param;

  localparam int NK = 3, CL = 4, TO = 16, MF = 3, LC = 32, OC = 8, FW = 2;
  localparam int M_WAIT = 0, M_ENTER = 1, M_OPEN = 2, M_PROG = 3, M_LOCK = 4;

  logic          Clk = 1'b0;
  logic          Rst, S, Prog;
  logic [NK-1:0] Keys;
  logic          U, Err, Locked, ProgMode;
  logic [FW-1:0] FailCnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode, position in code, idle run length, remaining window cycles.
  int m_mode, m_pos, m_idle, m_left, m_fail;
  bit m_err;
  int m_code[CL];
  int m_shadow[CL];

  logic [NK-1:0] dflt_seq[CL] = '{3'b100, 3'b001, 3'b010, 3'b100};
  logic [NK-1:0] new_seq[CL]  = '{3'b010, 3'b010, 3'b001, 3'b100};

  code_detector_param #(
    .NUM_KEYS(NK), .CODE_LEN(CL), .TIMEOUT(TO), .MAX_FAIL(MF),
    .LOCK_CYCLES(LC), .OPEN_CYCLES(OC)
  ) dut (
    .Clk(Clk), .Rst(Rst), .S(S), .Keys(Keys), .Prog(Prog),
    .U(U), .Err(Err), .Locked(Locked), .ProgMode(ProgMode), .FailCnt(FailCnt)
  );

  always #5 Clk = ~Clk;

  function automatic int key_index(input logic [NK-1:0] k);
    for (int i = 0; i < NK; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_WAIT; m_pos = 0; m_idle = 0; m_left = 0; m_fail = 0; m_err = 1'b0;
    m_code = '{2, 0, 1, 2};
  endtask

  task automatic model_step(input logic s, input logic [NK-1:0] k, input logic p);
    bit one;
    int ki;
    one = ($countones(k) == 1);
    ki  = key_index(k);
    m_err = 1'b0;
    case (m_mode)
      M_WAIT: if (s) begin m_mode = M_ENTER; m_pos = 0; m_idle = 0; end
      M_ENTER: begin
        if (k == 0) begin
          m_idle++;
          if (m_idle == TO) m_mode = M_WAIT;
        end else if (one && ki == m_code[m_pos]) begin
          m_idle = 0; m_pos++;
          if (m_pos == CL) begin m_mode = M_OPEN; m_left = OC; m_fail = 0; end
        end else begin
          m_err = 1'b1;
          if (m_fail < MF) m_fail++;
          if (m_fail == MF) begin m_mode = M_LOCK; m_left = LC; end
          else m_mode = M_WAIT;
        end
      end
      M_OPEN: begin
        if (p) begin m_mode = M_PROG; m_pos = 0; m_idle = 0; end
        else if (s) m_mode = M_WAIT;
        else begin m_left--; if (m_left == 0) m_mode = M_WAIT; end
      end
      M_PROG: begin
        if (k == 0) begin
          m_idle++;
          if (m_idle == TO) m_mode = M_WAIT;
        end else if (one) begin
          m_shadow[m_pos] = ki; m_pos++; m_idle = 0;
          if (m_pos == CL) begin m_code = m_shadow; m_mode = M_WAIT; end
        end else begin
          m_err = 1'b1; m_mode = M_WAIT;
        end
      end
      M_LOCK: begin
        m_left--;
        if (m_left == 0) begin m_mode = M_WAIT; m_fail = 0; end
      end
      default: m_mode = M_WAIT;
    endcase
  endtask

  function automatic logic [3+FW:0] obs();
    return {U, Err, Locked, ProgMode, FailCnt};
  endfunction

  function automatic logic [3+FW:0] expv();
    return {m_mode == M_OPEN, m_err, m_mode == M_LOCK, m_mode == M_PROG, FW'(m_fail)};
  endfunction

  task automatic tick(input logic s, input logic [NK-1:0] k, input logic p);
    S = s; Keys = k; Prog = p;
    @(posedge Clk);
    model_step(s, k, p);
    #1;
  endtask

  task automatic do_reset();
    S = 1'b0; Keys = '0; Prog = 1'b0;
    Rst = 1'b0;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    S = 1'b0; Keys = '0; Prog = 1'b0; Rst = 1'b1;
    #2 Rst = 1'b0;
    model_reset();
    #1;
    if (obs() !== expv()) begin $display("FAIL reset_async: got %b want %b", obs(), expv()); n_bad++; end
    n_cmp++;
    @(negedge Clk); @(negedge Clk);
    if (obs() !== expv()) begin $display("FAIL reset_held: got %b want %b", obs(), expv()); n_bad++; end
    n_cmp++;
    Rst = 1'b1;
    tick(1'b0, 3'b000, 1'b0);
    if (obs() !== expv()) begin $display("FAIL post_reset: got %b want %b", obs(), expv()); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_default_code();
    int u_cnt;
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < CL; i++) begin
      tick(1'b0, dflt_seq[i], 1'b0);
      if (obs() !== expv()) begin $display("FAIL default_code[%0d]: got %b want %b", i, obs(), expv()); n_bad++; end
      n_cmp++;
    end
    u_cnt = (U === 1'b1) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 3'b000, 1'b0);
      if (U === 1'b1) u_cnt++;
      if (obs() !== expv()) begin $display("FAIL open_window[%0d]: got %b want %b", i, obs(), expv()); n_bad++; end
      n_cmp++;
    end
    if (u_cnt != OC) begin $display("FAIL open_length: got %0d want %0d", u_cnt, OC); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_wrong_key();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b0, 3'b100, 1'b0);
    tick(1'b0, 3'b010, 1'b0);
    if ({Err, U, FailCnt} !== {1'b1, 1'b0, 2'd1}) begin
      $display("FAIL wrong_key: got Err/U/FailCnt=%b want 1_0_01", {Err, U, FailCnt}); n_bad++;
    end
    n_cmp++;
    tick(1'b0, 3'b000, 1'b0);
    if (obs() !== expv()) begin $display("FAIL wrong_key_after: got %b want %b", obs(), expv()); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_lockout();
    int lk_cnt;
    do_reset();
    for (int r = 0; r < MF; r++) begin
      tick(1'b1, 3'b000, 1'b0);
      tick(1'b0, 3'b010, 1'b0);
      if (obs() !== expv()) begin $display("FAIL lock_fail[%0d]: got %b want %b", r, obs(), expv()); n_bad++; end
      n_cmp++;
    end
    lk_cnt = (Locked === 1'b1) ? 1 : 0;
    for (int i = 0; i < LC; i++) begin
      if (i % 5 == 0) tick(1'b1, 3'b000, 1'b1);
      else            tick(1'b0, dflt_seq[(i % 5) - 1], 1'b0);
      if (Locked === 1'b1) lk_cnt++;
      if (obs() !== expv()) begin $display("FAIL lock_hold[%0d]: got %b want %b", i, obs(), expv()); n_bad++; end
      n_cmp++;
    end
    if (lk_cnt != LC) begin $display("FAIL lock_length: got %0d want %0d", lk_cnt, LC); n_bad++; end
    n_cmp++;
    tick(1'b0, 3'b000, 1'b0);
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < CL; i++) tick(1'b0, dflt_seq[i], 1'b0);
    if ({U, Locked, FailCnt} !== {1'b1, 1'b0, 2'd0}) begin
      $display("FAIL unlock_after_lock: got U/Locked/FailCnt=%b want 1_0_00", {U, Locked, FailCnt}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_timeout();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b0, 3'b100, 1'b0);
    for (int i = 0; i < TO; i++) begin
      tick(1'b0, 3'b000, 1'b0);
      if (obs() !== expv()) begin $display("FAIL timeout_idle[%0d]: got %b want %b", i, obs(), expv()); n_bad++; end
      n_cmp++;
    end
    for (int i = 1; i < CL; i++) begin
      tick(1'b0, dflt_seq[i], 1'b0);
      if ({U, Err, FailCnt} !== {1'b0, 1'b0, 2'd0}) begin
        $display("FAIL timeout_ignored[%0d]: got U/Err/FailCnt=%b want 0_0_00", i, {U, Err, FailCnt}); n_bad++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_program();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < CL; i++) tick(1'b0, dflt_seq[i], 1'b0);
    tick(1'b1, 3'b000, 1'b1);
    if ({U, ProgMode} !== 2'b01) begin $display("FAIL prog_enter: got U/ProgMode=%b want 01", {U, ProgMode}); n_bad++; end
    n_cmp++;
    for (int i = 0; i < CL; i++) begin
      tick(1'b0, new_seq[i], 1'b0);
      if (ProgMode !== (i < CL - 1)) begin
        $display("FAIL prog_mode[%0d]: got %b want %b", i, ProgMode, (i < CL - 1)); n_bad++;
      end
      n_cmp++;
    end
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b0, 3'b100, 1'b0);
    if (Err !== 1'b1) begin $display("FAIL old_code_rejected: got Err=%b want 1", Err); n_bad++; end
    n_cmp++;
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < CL; i++) tick(1'b0, new_seq[i], 1'b0);
    if ({U, FailCnt} !== {1'b1, 2'd0}) begin $display("FAIL new_code_opens: got U/FailCnt=%b want 1_00", {U, FailCnt}); n_bad++; end
    n_cmp++;
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < CL; i++) tick(1'b0, dflt_seq[i], 1'b0);
    if (U !== 1'b1) begin $display("FAIL default_restored: got U=%b want 1", U); n_bad++; end
    n_cmp++;
  endtask

  task automatic test_invalid_async();
    do_reset();
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b0, 3'b110, 1'b0);
    if ({Err, FailCnt} !== {1'b1, 2'd1}) begin $display("FAIL invalid_press: got Err/FailCnt=%b want 1_01", {Err, FailCnt}); n_bad++; end
    n_cmp++;
    tick(1'b1, 3'b000, 1'b0);
    tick(1'b0, 3'b100, 1'b0);
    #2 Rst = 1'b0;
    model_reset();
    #1;
    if (obs() !== 6'b0) begin $display("FAIL async_reset: got %b want 000000", obs()); n_bad++; end
    n_cmp++;
    @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_random();
    int r, j;
    logic s, p;
    logic [NK-1:0] k;
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      r = $urandom_range(0, 11);
      if (m_mode == M_ENTER && r < 5) k = NK'(1 << m_code[m_pos]);
      else if (r < 8) k = NK'(1 << $urandom_range(0, NK - 1));
      else if (r < 10) k = '0;
      else begin
        j = $urandom_range(0, 3);
        k = 3'b111;
        if (j < 3) k[j] = 1'b0;
      end
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 5) == 0);
      tick(s, k, p);
      if (obs() !== expv()) begin $display("FAIL random[%0d]: got %b want %b", c, obs(), expv()); n_bad++; end
      n_cmp++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_default_code();
    test_wrong_key();
    test_lockout();
    test_timeout();
    test_program();
    test_invalid_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
